// File: rtl/approx_error_monitor_if.sv
// Sample/result bus of the approximate-multiplier error monitor.
// Handshake: a sample (exact_p, approx_p) transfers on a rising edge where
// in_valid and in_ready are both high; in_ready depends only on FSM state,
// never on in_valid, and in_valid while in_ready is low is simply dropped.
interface approx_error_monitor_if #(
    parameter int N        = 8,
    parameter int WIN_LOG2 = 8
);
    logic                      start;
    logic                      in_valid;
    logic                      in_ready;
    logic [2*N-1:0]            exact_p;
    logic [2*N-1:0]            approx_p;
    logic                      busy;
    logic                      done;
    logic [2*N+WIN_LOG2-1:0]   sum_ed;
    logic [2*N-1:0]            mean_ed;
    logic [2*N-1:0]            max_ed;
    logic [WIN_LOG2:0]         err_count;

    modport master (
        output start, in_valid, exact_p, approx_p,
        input  in_ready, busy, done, sum_ed, mean_ed, max_ed, err_count
    );

    modport slave (
        input  start, in_valid, exact_p, approx_p,
        output in_ready, busy, done, sum_ed, mean_ed, max_ed, err_count
    );
endinterface

// File: rtl/approx_error_monitor.sv
// Windowed error-distance statistics for an exact/approximate multiplier pair.
// Stage 1 registers |exact - approx|, stage 2 folds it into sum, max and
// nonzero count. The FSM opens a window on start, accepts 2^WIN_LOG2 samples,
// spends one DRAIN cycle so stage 2 absorbs the last one, then pulses done.
module approx_error_monitor #(
    parameter int N        = 8,
    parameter int WIN_LOG2 = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    approx_error_monitor_if.slave     bus,
    output logic [1:0]                fsm_state
);
    localparam int W  = 2 * N;
    localparam int SW = 2 * N + WIN_LOG2;
    localparam logic [WIN_LOG2:0] LAST_IDX = (WIN_LOG2 + 1)'((1 << WIN_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic              clear;
    logic              accept;
    logic [W-1:0]      ed;
    logic [WIN_LOG2:0] sample_count;
    logic              s1_valid;
    logic [W-1:0]      s1_ed;
    logic [SW-1:0]     sum_q;
    logic [W-1:0]      max_q;
    logic [WIN_LOG2:0] err_q;

    assign accept = bus.in_valid & in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and per-state handshake/status outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        clear      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    clear      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // count still holds the pre-accept value, so LAST_IDX means this accept fills the window
                if (accept && (sample_count == LAST_IDX)) state_next = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Absolute difference of the two products, unsigned
    always_comb begin
        if (bus.exact_p >= bus.approx_p) ed = bus.exact_p - bus.approx_p;
        else                             ed = bus.approx_p - bus.exact_p;
    end

    // Sample counter for the current window
    always_ff @(posedge clk) begin
        if (rst || clear)  sample_count <= '0;
        else if (accept)   sample_count <= sample_count + 1'b1;
    end

    // Stage 1: capture the error distance of each accepted sample
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s1_valid <= 1'b0;
            s1_ed    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) s1_ed <= ed;
        end
    end

    // Stage 2: accumulate sum, running max and nonzero-error count
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum_q <= '0;
            max_q <= '0;
            err_q <= '0;
        end else if (s1_valid) begin
            sum_q <= sum_q + {{WIN_LOG2{1'b0}}, s1_ed};
            if (s1_ed > max_q) max_q <= s1_ed;
            err_q <= err_q + {{WIN_LOG2{1'b0}}, (s1_ed != '0)};
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.sum_ed    = sum_q;
    assign bus.mean_ed   = sum_q[SW-1:WIN_LOG2];
    assign bus.max_ed    = max_q;
    assign bus.err_count = err_q;
    assign fsm_state     = state;
endmodule

// File: doc/approx_error_monitor.md
# approx_error_monitor

Downstream error-metrics stage for the exact/approximate multiplier pair. Each accepted sample is one exact product and its approximate counterpart, both computed from the same operands. Over a window of 2^WIN_LOG2 accepted samples, the block accumulates the absolute error distance (ED) and reports sum, mean, maximum and nonzero-error count, so the approximate path can be characterised in hardware.

## Interface
- N, default 8: multiplier operand width; products are 2N bits unsigned.
- WIN_LOG2, default 8: log2 of window length; window = 2^WIN_LOG2 samples (WIN_LOG2 ≥ 1).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new window; honoured only in IDLE.
- in_valid  in  1  exact_p/approx_p valid this cycle.
- in_ready  out  1  block accepts a sample this cycle.
- exact_p  in  2N  exact product.
- approx_p  in  2N  approximate product.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when window results are final.
- sum_ed  out  2N+WIN_LOG2  sum of |exact_p − approx_p| over window.
- mean_ed  out  2N  sum_ed >> WIN_LOG2 (truncating).
- max_ed  out  2N  largest ED in window.
- err_count  out  WIN_LOG2+1  number of samples with ED ≠ 0.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 → clear sum/max/err_count/sample counter and stage-1 register; next state RUN.
- RUN:
  - in_ready=1, busy=1.
  - Accept a sample when in_valid & in_ready.
  - Sample counter (WIN_LOG2+1 bits) increments per accept.
  - On the accept that brings the count to 2^WIN_LOG2 → next state DRAIN.
  - start is ignored.
- DRAIN: in_ready=0, busy=1; lets stage 2 absorb the last sample; next state DONE unconditionally.
- DONE: done=1 for this single cycle; next state IDLE; start ignored.
- Pipeline, two stages:
  - Stage 1 registers ed = (exact_p ≥ approx_p) ? exact_p − approx_p : approx_p − exact_p (2N bits, unsigned compare), plus a valid bit.
  - Stage 2, when stage-1 valid:
    - sum_ed += ed
    - max_ed = max(max_ed, ed)
    - err_count += (ed ≠ 0)
- Width rules:
  - sum_ed cannot overflow: 2^WIN_LOG2·(2^2N−1) fits in 2N+WIN_LOG2 bits.
  - err_count max is 2^WIN_LOG2.
  - mean_ed is combinational from registered sum_ed.
- Outputs hold the last window's results through IDLE until the next accepted start clears them.
- in_valid while in_ready=0 is ignored; no data is captured.

## Timing
- Reset values:
  - state IDLE.
  - in_ready, busy and done = 0.
  - sum_ed, mean_ed, max_ed and err_count = 0.
  - Stage-1 valid = 0; sample counter = 0.
- start sampled high in IDLE at edge t → in_ready=1 from cycle t+1.
- Sample accepted in cycle c → stage-1 valid in c+1 → accumulators updated at end of c+1, visible in c+2.
- Last sample accepted in cycle L:
  - DRAIN in L+1 (in_ready=0).
  - DONE in L+2 (done=1, all outputs final).
  - IDLE in L+3.
- Gaps in in_valid stretch RUN but do not change results.
- rst=1 in any state (including mid-window) → reset values at the next edge. The partial window is discarded and does not produce done.
- rst has priority over start and in_valid in the same cycle.

## Test plan
Parameters: N=8, WIN_LOG2=2 (window 4).
- Reset: hold rst 2 cycles → all outputs 0, in_ready=0, busy=0. Release with no start → stays idle, outputs 0.
- Uniform error: start, then 4 back-to-back samples exact_p=100, approx_p=96 → done 2 cycles after last accept. Results: sum_ed=16, mean_ed=4, max_ed=4, err_count=4.
- Both signs and extremes: samples (50,60), (0,0), (65025,0), (7,7) → sum_ed=65035, mean_ed=16258, max_ed=65025, err_count=2.
- Gapped input: same 4 samples as the uniform-error case with in_valid low 1–3 cycles between them, plus in_valid=1 during IDLE/DRAIN → identical results to the uniform-error case; exactly 4 samples accepted.
- Reset mid-window: after 2 accepted samples of (100,96), assert rst 1 cycle → outputs 0, IDLE, no done pulse. A new start plus 4×(10,13) → sum_ed=12, max_ed=3, err_count=4.
- Start handling: start pulsed during RUN and during the DONE cycle → ignored, results unchanged. Start one cycle after DONE (in IDLE) → outputs cleared, in_ready=1 the following cycle.
